// File: rtl/mips_core_pkg.sv
// Shared types and constants for the MIPS core front end.
// Fetch state encoding is shared with any future pipelined fetch unit.
package mips_core_pkg;

  typedef logic [15:0] pc_t;
  typedef logic [31:0] instr_t;

  localparam pc_t PC_INC = 16'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select: word-aligned redirect target, sequential PC+4, or hold.
// Redirect wins over advance so a taken branch is never lost to a completing fetch.
module pc_next_sel
  import mips_core_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            advance_i,
  input  logic [PC_W-1:0] pc_i,
  output logic [PC_W-1:0] pc_next_o
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
  localparam logic [PC_W-1:0] INC        = PC_W'(PC_INC);

  always_comb begin
    pc_next_o = pc_i;
    if (redirect_i) begin
      pc_next_o = redirect_pc_i & ALIGN_MASK;
    end else if (advance_i) begin
      pc_next_o = pc_i + INC;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle instruction-fetch controller: owns the PC, runs one imem
// request/response at a time and hands the word to decode with valid/ready.
module fetch_sequencer
  import mips_core_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_redirect,
  input  logic [PC_W-1:0]    i_redirect_pc,
  output logic               o_imem_req,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic               i_imem_ready,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_instr_pc,
  input  logic               i_instr_ready,
  output logic               o_busy
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               discard_q, discard_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               advance;
  logic               imem_accept;

  assign imem_accept = (state_q == REQ) && i_imem_ready;

  pc_next_sel #(
    .PC_W (PC_W)
  ) u_pc_next_sel (
    .redirect_i    (i_redirect),
    .redirect_pc_i (i_redirect_pc),
    .advance_i     (advance),
    .pc_i          (pc_q),
    .pc_next_o     (pc_d)
  );

  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    advance       = 1'b0;

    case (state_q)
      IDLE: begin
        // a redirect while idle only retargets the PC; the start waits a cycle
        if (!i_redirect && i_en) begin
          state_d = REQ;
        end
      end

      REQ: begin
        if (imem_accept) begin
          state_d   = WAIT;
          discard_d = i_redirect;
        end
      end

      WAIT: begin
        if (i_imem_rvalid) begin
          if (discard_q || i_redirect) begin
            discard_d = 1'b0;
            state_d   = i_en ? REQ : IDLE;
          end else begin
            instr_d       = i_imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            advance       = 1'b1;
            state_d       = HOLD;
          end
        end else if (i_redirect) begin
          discard_d = 1'b1;
        end
      end

      HOLD: begin
        if (i_redirect || i_instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = i_en ? REQ : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      discard_q     <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      discard_q     <= discard_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign o_imem_req    = (state_q == REQ);
  assign o_imem_addr   = pc_q;
  assign o_instr_valid = instr_valid_q;
  assign o_instr       = instr_q;
  assign o_instr_pc    = instr_pc_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: latency-programmable imem model, decode-side
// scoreboard, and a second instance built with RESET_PC at the top of memory.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic        o_imem_req;
  logic [15:0] o_imem_addr;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [15:0] o_instr_pc;
  logic        o_busy;

  logic        en_w;
  logic        rvalid_w;
  logic [31:0] rdata_w;
  logic        req_w;
  logic [15:0] addr_w;
  logic        valid_w;
  logic [31:0] instr_w;
  logic [15:0] instr_pc_w;
  logic        busy_w;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_acc    = 0;
  int          lat      = 0;
  logic [47:0] sb_q[$];

  fetch_sequencer #(.PC_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (imem_ready),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_instr_ready (instr_ready),
    .o_busy        (o_busy)
  );

  fetch_sequencer #(.PC_W(16), .INSTR_W(32), .RESET_PC(16'hFFFC)) u_dut_wrap (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en_w),
    .i_redirect    (1'b0),
    .i_redirect_pc (16'h0000),
    .o_imem_req    (req_w),
    .o_imem_addr   (addr_w),
    .i_imem_ready  (1'b1),
    .i_imem_rvalid (rvalid_w),
    .i_imem_rdata  (rdata_w),
    .o_instr_valid (valid_w),
    .o_instr       (instr_w),
    .o_instr_pc    (instr_pc_w),
    .i_instr_ready (1'b1),
    .o_busy        (busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [15:0] a);
    return 32'h2000_0001 + {a, 16'h0000};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!o_instr_valid && n < budget) begin
      tick();
      n++;
    end
    chk("to_valid", 64'(o_instr_valid), 64'(1));
  endtask

  task automatic wait_wait(input int budget);
    int n = 0;
    while (!(o_busy && !o_imem_req && !o_instr_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("to_wait", 64'(o_busy && !o_imem_req && !o_instr_valid), 64'(1));
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!o_imem_req && n < budget) begin
      tick();
      n++;
    end
    chk("to_req", 64'(o_imem_req), 64'(1));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      tick();
      n++;
    end
    chk("to_idle", 64'(o_busy), 64'(0));
  endtask

  task automatic sb_push(input logic [15:0] pc);
    sb_q.push_back({pc, mem_fn(pc)});
  endtask

  // imem model: one outstanding access, response lat extra cycles after the earliest slot
  initial begin
    logic        acc;
    logic [15:0] a;
    logic [15:0] pa;
    int          cnt;
    logic        pend;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend        = 1'b0;
    cnt         = 0;
    pa          = '0;
    forever begin
      @(negedge clk);
      acc = o_imem_req && imem_ready;
      a   = o_imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_fn(pa);
          pend        = 1'b0;
        end
      end
      if (acc) begin
        pa = a;
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_fn(a);
        end else begin
          cnt  = lat;
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    logic        acc_w;
    logic [15:0] a_w;
    rvalid_w = 1'b0;
    rdata_w  = '0;
    forever begin
      @(negedge clk);
      acc_w = req_w;
      a_w   = addr_w;
      @(posedge clk);
      #1;
      rvalid_w = acc_w;
      rdata_w  = mem_fn(a_w);
    end
  end

  // decode-side scoreboard: every accepted instruction must match the next expectation
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (o_instr_valid && instr_ready) begin
        n_acc++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 64'(sb_q.size()), 64'(1));
        end else begin
          e = sb_q.pop_front();
          chk("sb_pc_instr", 64'({o_instr_pc, o_instr}), 64'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int n;
    rst         = 1'b1;
    en          = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b1;
    instr_ready = 1'b1;
    en_w        = 1'b0;
    tick();
    tick();

    chk("rst_ctl",      64'({o_busy, o_imem_req, o_instr_valid}), 64'(3'b000));
    chk("rst_addr",     64'(o_imem_addr), 64'(16'h0000));
    chk("rst_instr",    64'(o_instr), 64'(0));
    chk("rst_instr_pc", 64'(o_instr_pc), 64'(0));
    chk("rst_wrap_pc",  64'(addr_w), 64'(16'hFFFC));

    // zero-wait fetch from reset
    rst = 1'b0;
    en  = 1'b1;
    sb_push(16'h0000);
    tick();
    chk("t1_req",   64'({o_imem_req, o_imem_addr}), 64'({1'b1, 16'h0000}));
    tick();
    chk("t1_wait",  64'({o_busy, o_imem_req, o_instr_valid}), 64'(3'b100));
    tick();
    chk("t1_valid", 64'(o_instr_valid), 64'(1));
    chk("t1_instr", 64'(o_instr), 64'(32'h2000_0001));
    chk("t1_pc",    64'(o_instr_pc), 64'(16'h0000));
    tick();
    chk("t1_next",  64'({o_imem_req, o_imem_addr}), 64'({1'b1, 16'h0004}));

    // ready low two cycles, response three cycles late
    imem_ready = 1'b0;
    sb_push(16'h0004);
    tick();
    chk("t2_hold_a", 64'({o_imem_req, o_imem_addr}), 64'({1'b1, 16'h0004}));
    tick();
    chk("t2_hold_b", 64'({o_imem_req, o_imem_addr}), 64'({1'b1, 16'h0004}));
    imem_ready = 1'b1;
    lat        = 3;
    en         = 1'b0;
    wait_valid(20, n);
    chk("t2_lat", 64'(n), 64'(5));
    chk("t2_pc",  64'(o_instr_pc), 64'(16'h0004));
    tick();
    wait_idle(10);

    // redirect while idle retargets without starting
    redirect    = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    chk("t3_idle_redir", 64'({o_busy, o_imem_addr}), 64'({1'b0, 16'h0010}));

    // redirect during WAIT drops the in-flight response
    en  = 1'b1;
    lat = 2;
    sb_push(16'h0120);
    wait_wait(10);
    chk("t3_wait_addr", 64'(o_imem_addr), 64'(16'h0010));
    redirect    = 1'b1;
    redirect_pc = 16'h0123;
    tick();
    redirect = 1'b0;
    chk("t3_still_wait", 64'({o_busy, o_imem_req, o_instr_valid}), 64'(3'b100));
    wait_req(10);
    chk("t3_new_addr", 64'(o_imem_addr), 64'(16'h0120));
    en = 1'b0;
    wait_valid(10, n);
    chk("t3_pc", 64'(o_instr_pc), 64'(16'h0120));
    tick();
    wait_idle(10);

    // redirect in HOLD while decode stalls
    instr_ready = 1'b0;
    lat         = 0;
    en          = 1'b1;
    wait_valid(10, n);
    chk("t4_lat", 64'(n), 64'(3));
    chk("t4_pc",  64'(o_instr_pc), 64'(16'h0124));
    tick();
    chk("t4_stable", 64'({o_instr_valid, o_instr_pc, o_instr}),
        64'({1'b1, 16'h0124, mem_fn(16'h0124)}));
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("t4_drop", 64'({o_busy, o_imem_req, o_instr_valid}), 64'(3'b110));
    chk("t4_addr", 64'(o_imem_addr), 64'(16'h0040));
    sb_push(16'h0040);
    instr_ready = 1'b1;
    wait_valid(10, n);
    chk("t4_new_pc", 64'(o_instr_pc), 64'(16'h0040));
    en = 1'b0;
    tick();
    wait_idle(10);

    // reset in WAIT with a late response arriving afterwards
    en  = 1'b1;
    lat = 1;
    wait_wait(10);
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    chk("t5_rst_ctl",   64'({o_busy, o_imem_req, o_instr_valid}), 64'(3'b000));
    chk("t5_rst_addr",  64'(o_imem_addr), 64'(16'h0000));
    chk("t5_rst_instr", 64'({o_instr, o_instr_pc}), 64'(0));
    tick();
    chk("t5_ignored",   64'({o_busy, o_instr_valid}), 64'(2'b00));
    lat = 0;
    en  = 1'b1;
    sb_push(16'h0000);
    wait_valid(10, n);
    chk("t5_lat", 64'(n), 64'(3));
    en = 1'b0;
    tick();
    wait_idle(10);

    // PC wrap from 0xFFFC, steady three-cycle cadence
    en_w = 1'b1;
    n = 0;
    while (!valid_w && n < 10) begin
      tick();
      n++;
    end
    chk("t6_lat0",  64'(n), 64'(3));
    chk("t6_first", 64'({instr_pc_w, instr_w}), 64'({16'hFFFC, mem_fn(16'hFFFC)}));
    tick();
    n = 1;
    while (!valid_w && n < 10) begin
      tick();
      n++;
    end
    chk("t6_period", 64'(n), 64'(3));
    chk("t6_second", 64'({instr_pc_w, instr_w}), 64'({16'h0000, mem_fn(16'h0000)}));
    en_w = 1'b0;
    tick();
    tick();

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    chk("accepts",    64'(n_acc), 64'(5));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
